// File: rtl/axi_sram_slave_if.sv
// AXI3 slave-side bus bundle for axi_sram_slave: the five AXI channels
// plus the single-port synchronous SRAM port the slave drives.
interface axi_sram_slave_if #(
  parameter int ID_W    = 4,
  parameter int SRAM_AW = 16
) ();
  // read address channel
  logic [ID_W-1:0]    axi_ar_id;
  logic [31:0]        axi_ar_addr;
  logic [7:0]         axi_ar_len;
  logic [2:0]         axi_ar_size;
  logic [1:0]         axi_ar_burst;
  logic [1:0]         axi_ar_lock;
  logic [3:0]         axi_ar_cache;
  logic [2:0]         axi_ar_prot;
  logic               axi_ar_valid;
  logic               axi_ar_ready;
  // read data channel
  logic [ID_W-1:0]    axi_r_id;
  logic [31:0]        axi_r_data;
  logic [1:0]         axi_r_resp;
  logic               axi_r_last;
  logic               axi_r_valid;
  logic               axi_r_ready;
  // write address channel
  logic [ID_W-1:0]    axi_aw_id;
  logic [31:0]        axi_aw_addr;
  logic [7:0]         axi_aw_len;
  logic [2:0]         axi_aw_size;
  logic [1:0]         axi_aw_burst;
  logic [1:0]         axi_aw_lock;
  logic [3:0]         axi_aw_cache;
  logic [2:0]         axi_aw_prot;
  logic               axi_aw_valid;
  logic               axi_aw_ready;
  // write data channel
  logic [ID_W-1:0]    axi_w_id;
  logic [31:0]        axi_w_data;
  logic [3:0]         axi_w_strb;
  logic               axi_w_last;
  logic               axi_w_valid;
  logic               axi_w_ready;
  // write response channel
  logic [ID_W-1:0]    axi_b_id;
  logic [1:0]         axi_b_resp;
  logic               axi_b_valid;
  logic               axi_b_ready;
  // SRAM port (rdata valid the cycle after en with wen == 0)
  logic               sram_en;
  logic [3:0]         sram_wen;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;

  modport slave (
    input  axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst,
           axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_valid,
    output axi_ar_ready,
    output axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
    input  axi_r_ready,
    input  axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst,
           axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_valid,
    output axi_aw_ready,
    input  axi_w_id, axi_w_data, axi_w_strb, axi_w_last, axi_w_valid,
    output axi_w_ready,
    output axi_b_id, axi_b_resp, axi_b_valid,
    input  axi_b_ready,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst,
           axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_valid,
    input  axi_ar_ready,
    input  axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
    output axi_r_ready,
    output axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst,
           axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_valid,
    input  axi_aw_ready,
    output axi_w_id, axi_w_data, axi_w_strb, axi_w_last, axi_w_valid,
    input  axi_w_ready,
    input  axi_b_id, axi_b_resp, axi_b_valid,
    output axi_b_ready,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves one transaction at a time out of a single-port
// synchronous SRAM with 1-cycle read latency. FIXED/INCR/WRAP bursts; reads
// have fixed priority over writes when both address channels are valid.
module axi_sram_slave #(
  parameter int ID_W    = 4,
  parameter int SRAM_AW = 16
) (
  input  logic            clock,
  input  logic            reset,
  axi_sram_slave_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_REQ,
    S_R_CAP,
    S_R_DATA,
    S_W_DATA,
    S_W_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [31:0]     r_rdata_q;
  logic            r_size_err;   // size wider than the 32-bit bus
  logic            r_last_err;   // w_last disagreed with the beat counter

  logic            w_beat_last;
  logic [31:0]     w_step;
  logic [31:0]     w_wrap_mask;
  logic [31:0]     w_addr_next;

  assign w_beat_last = (r_beat == r_len);

  // next beat address for the latched burst type
  always_comb begin
    w_step      = 32'd1 << r_size;
    w_wrap_mask = ((({24'd0, r_len}) + 32'd1) << r_size) - 32'd1;
    w_addr_next = r_addr + w_step;
    case (r_burst)
      2'b00:   w_addr_next = r_addr;
      2'b10:   w_addr_next = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default: w_addr_next = r_addr + w_step;  // INCR, and reserved 2'b11 behaves as INCR
    endcase
  end

  // FSM next state and handshake/SRAM strobes
  always_comb begin
    w_state_next    = r_state;
    io.axi_ar_ready = 1'b0;
    io.axi_aw_ready = 1'b0;
    io.axi_r_valid  = 1'b0;
    io.axi_w_ready  = 1'b0;
    io.axi_b_valid  = 1'b0;
    io.sram_en      = 1'b0;
    io.sram_wen     = 4'h0;
    case (r_state)
      S_IDLE: begin
        io.axi_ar_ready = 1'b1;
        io.axi_aw_ready = !io.axi_ar_valid;
        if (io.axi_ar_valid)      w_state_next = S_R_REQ;
        else if (io.axi_aw_valid) w_state_next = S_W_DATA;
      end
      S_R_REQ: begin
        io.sram_en   = 1'b1;
        w_state_next = S_R_CAP;
      end
      S_R_CAP: begin
        w_state_next = S_R_DATA;
      end
      S_R_DATA: begin
        io.axi_r_valid = 1'b1;
        if (io.axi_r_ready) w_state_next = w_beat_last ? S_IDLE : S_R_REQ;
      end
      S_W_DATA: begin
        io.axi_w_ready = 1'b1;
        if (io.axi_w_valid) begin
          io.sram_en  = 1'b1;
          io.sram_wen = r_size_err ? 4'h0 : io.axi_w_strb;
          if (w_beat_last) w_state_next = S_W_RESP;
        end
      end
      S_W_RESP: begin
        io.axi_b_valid = 1'b1;
        if (io.axi_b_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // nothing may be accepted or issued to the SRAM while reset is held
    if (reset) begin
      io.axi_ar_ready = 1'b0;
      io.axi_aw_ready = 1'b0;
      io.sram_en      = 1'b0;
      io.sram_wen     = 4'h0;
      w_state_next    = S_IDLE;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // transaction context: latched address phase, beat counter, read capture, error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_rdata_q  <= '0;
      r_size_err <= 1'b0;
      r_last_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.axi_ar_valid) begin
            r_id       <= io.axi_ar_id;
            r_addr     <= io.axi_ar_addr;
            r_len      <= io.axi_ar_len;
            r_size     <= io.axi_ar_size;
            r_burst    <= io.axi_ar_burst;
            r_size_err <= (io.axi_ar_size > 3'd2);
            r_last_err <= 1'b0;
            r_beat     <= '0;
          end else if (io.axi_aw_valid) begin
            r_id       <= io.axi_aw_id;
            r_addr     <= io.axi_aw_addr;
            r_len      <= io.axi_aw_len;
            r_size     <= io.axi_aw_size;
            r_burst    <= io.axi_aw_burst;
            r_size_err <= (io.axi_aw_size > 3'd2);
            r_last_err <= 1'b0;
            r_beat     <= '0;
          end
        end
        S_R_CAP: begin
          r_rdata_q <= io.sram_rdata;
        end
        S_R_DATA: begin
          if (io.axi_r_ready && !w_beat_last) begin
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        S_W_DATA: begin
          if (io.axi_w_valid) begin
            if (io.axi_w_last != w_beat_last) r_last_err <= 1'b1;
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // channel payloads come straight from the latched context
  assign io.axi_r_id    = r_id;
  assign io.axi_r_data  = r_rdata_q;
  assign io.axi_r_last  = (r_state == S_R_DATA) && w_beat_last;
  assign io.axi_r_resp  = r_size_err ? 2'b10 : 2'b00;
  assign io.axi_b_id    = r_id;
  assign io.axi_b_resp  = (r_size_err || r_last_err) ? 2'b10 : 2'b00;
  assign io.sram_addr   = r_addr[SRAM_AW+1:2];
  assign io.sram_wdata  = io.axi_w_data;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: SRAM device model, transaction-level reference
// model (expected SRAM accesses, R beats, B responses), per-cycle compare
// process, directed scenarios and randomized bursts.
module tb_axi_sram_slave;
  localparam int ID_W    = 4;
  localparam int SRAM_AW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_sram_slave_if #(.ID_W(ID_W), .SRAM_AW(SRAM_AW)) bus ();
  axi_sram_slave #(.ID_W(ID_W), .SRAM_AW(SRAM_AW)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { logic [15:0] addr; logic [3:0] wen; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] data; logic last; logic [3:0] id; logic [1:0] resp; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

  acc_t   acc_q[$];
  rbeat_t r_q[$];
  bresp_t b_q[$];
  logic [15:0] sram_log[$];
  logic [3:0]  wen_log[$];
  logic [31:0] last_bits = 0;
  logic [3:0]  last_bid  = 0;
  logic [1:0]  last_bresp = 0;

  logic [31:0] ref_mem [0:65535];
  logic [31:0] mem     [0:65535];
  bit          mem_ready = 0;
  int          ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

  function automatic logic [31:0] word_init(input int k);
    if (k == 4) return 32'hDEADBEEF;
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, want handshake", name);
  endtask

  // byte address of beat i of a burst, straight from the burst definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, bound, off;
    step = 32'd1 << size;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      bound = (32'(len) + 32'd1) * step;
      off   = start % bound;
      return (start - off) + ((off + 32'(i) * step) % bound);
    end
    return start + 32'(i) * step;
  endfunction

  // SRAM device: 1-cycle registered read, byte-enabled write
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int k = 0; k < 65536; k++) mem[k] <= word_init(k);
      mem_ready <= 1;
    end else if (bus.sram_en) begin
      if (bus.sram_wen == 4'h0) bus.sram_rdata <= mem[bus.sram_addr];
      else for (int b = 0; b < 4; b++)
        if (bus.sram_wen[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
    end
  end

  // master-side ready generation
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      1: begin bus.axi_r_ready = 1'b0; bus.axi_b_ready = 1'b0; end
      2: begin bus.axi_r_ready = 1'b1; bus.axi_b_ready = 1'b1; end
      default: begin
        bus.axi_r_ready = ($urandom_range(0, 3) != 0);
        bus.axi_b_ready = ($urandom_range(0, 2) != 0);
      end
    endcase
  end

  // compare process: every SRAM access, R beat and B response against the model
  always @(negedge clock) begin : mon
    acc_t a;
    rbeat_t rb;
    bresp_t bb;
    if (!reset) begin
      if (bus.sram_en) begin
        sram_log.push_back(bus.sram_addr);
        wen_log.push_back(bus.sram_wen);
        if (acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sram_access: got en addr %0h, want no access", bus.sram_addr);
        end else begin
          a = acc_q.pop_front();
          chk("sram_addr", bus.sram_addr, a.addr);
          chk("sram_wen", bus.sram_wen, a.wen);
          if (a.wen != 4'h0) chk("sram_wdata", bus.sram_wdata, a.wdata);
        end
      end
      if (bus.axi_r_valid && bus.axi_r_ready) begin
        last_bits = {last_bits[30:0], bus.axi_r_last};
        if (r_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_beat: got beat data %0h, want none", bus.axi_r_data);
        end else begin
          rb = r_q.pop_front();
          chk("r_data", bus.axi_r_data, rb.data);
          chk("r_last", bus.axi_r_last, rb.last);
          chk("r_id", bus.axi_r_id, rb.id);
          chk("r_resp", bus.axi_r_resp, rb.resp);
        end
      end
      if (bus.axi_b_valid && bus.axi_b_ready) begin
        last_bid   = bus.axi_b_id;
        last_bresp = bus.axi_b_resp;
        if (b_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_resp: got id %0h, want none", bus.axi_b_id);
        end else begin
          bb = b_q.pop_front();
          chk("b_id", bus.axi_b_id, bb.id);
          chk("b_resp", bus.axi_b_resp, bb.resp);
        end
      end
    end
  end

  task automatic push_read_model(input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    acc_t a; rbeat_t rb; logic [31:0] ba;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(addr, i, len, size, burst);
      a.addr = ba[17:2]; a.wen = 4'h0; a.wdata = 32'h0;
      acc_q.push_back(a);
      rb.data = ref_mem[ba[17:2]]; rb.last = (i == int'(len)); rb.id = id;
      rb.resp = (size > 3'd2) ? 2'b10 : 2'b00;
      r_q.push_back(rb);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || acc_q.size() != 0) && n < 600) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 600) begin
      timeout_fail("txn_complete");
      r_q.delete(); b_q.delete(); acc_q.delete();
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.axi_ar_id = id; bus.axi_ar_addr = addr; bus.axi_ar_len = len;
    bus.axi_ar_size = size; bus.axi_ar_burst = burst; bus.axi_ar_valid = 1'b1;
    do begin @(negedge clock); n++; end while (!bus.axi_ar_ready && n < 200);
    if (!bus.axi_ar_ready) begin timeout_fail("ar_ready"); bus.axi_ar_valid = 1'b0; return; end
    @(posedge clock); #1;
    bus.axi_ar_valid = 1'b0;
    push_read_model(id, addr, len, size, burst);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    send_ar(id, addr, len, size, burst);
    wait_done();
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
      input logic [3:0] fixed_strb, input bit seq_data, input int bad_last, input int rst_beat);
    logic [31:0] d [256];
    logic [3:0]  s [256];
    logic [31:0] ba;
    acc_t a; bresp_t b; bit err; int n;
    err = (size > 3'd2) || (bad_last >= 0 && bad_last <= int'(len));
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = seq_data ? 32'(i + 1) : $urandom;
      s[i] = (fixed_strb != 4'h0) ? fixed_strb : 4'($urandom_range(0, 15));
    end
    bus.axi_aw_id = id; bus.axi_aw_addr = addr; bus.axi_aw_len = len;
    bus.axi_aw_size = size; bus.axi_aw_burst = burst; bus.axi_aw_valid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.axi_aw_ready && n < 200);
    if (!bus.axi_aw_ready) begin timeout_fail("aw_ready"); bus.axi_aw_valid = 1'b0; return; end
    @(posedge clock); #1;
    bus.axi_aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(addr, i, len, size, burst);
      a.addr = ba[17:2]; a.wen = (size > 3'd2) ? 4'h0 : s[i]; a.wdata = d[i];
      acc_q.push_back(a);
    end
    b.id = id; b.resp = err ? 2'b10 : 2'b00;
    b_q.push_back(b);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == rst_beat) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        acc_q.delete(); r_q.delete(); b_q.delete();
        return;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      bus.axi_w_data = d[i]; bus.axi_w_strb = s[i];
      bus.axi_w_last = (i == int'(len)) ^ (i == bad_last);
      bus.axi_w_valid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!bus.axi_w_ready && n < 200);
      if (!bus.axi_w_ready) begin timeout_fail("w_ready"); bus.axi_w_valid = 1'b0; return; end
      @(posedge clock); #1;
      bus.axi_w_valid = 1'b0;
      if (size <= 3'd2) begin
        ba = beat_addr(addr, i, len, size, burst);
        for (int k = 0; k < 4; k++)
          if (s[i][k]) ref_mem[ba[17:2]][8*k +: 8] = d[i][8*k +: 8];
      end
    end
    wait_done();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rid; logic [31:0] raddr; logic [7:0] rlen; logic [2:0] rsize; logic [1:0] rburst;
    int n; bit leak;
    for (int k = 0; k < 65536; k++) ref_mem[k] = word_init(k);
    bus.axi_ar_id = 0; bus.axi_ar_addr = 0; bus.axi_ar_len = 0; bus.axi_ar_size = 0;
    bus.axi_ar_burst = 0; bus.axi_ar_lock = 0; bus.axi_ar_cache = 0; bus.axi_ar_prot = 0;
    bus.axi_aw_id = 0; bus.axi_aw_addr = 0; bus.axi_aw_len = 0; bus.axi_aw_size = 0;
    bus.axi_aw_burst = 0; bus.axi_aw_lock = 0; bus.axi_aw_cache = 0; bus.axi_aw_prot = 0;
    bus.axi_w_id = 0; bus.axi_w_data = 0; bus.axi_w_strb = 0; bus.axi_w_last = 0;
    bus.axi_w_valid = 0;
    // both address valids high during reset: readies must stay low
    reset = 1'b1;
    bus.axi_ar_valid = 1'b1; bus.axi_aw_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ar_ready", bus.axi_ar_ready, 0);
    chk("rst_aw_ready", bus.axi_aw_ready, 0);
    bus.axi_ar_valid = 1'b0; bus.axi_aw_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_r_valid", bus.axi_r_valid, 0);
    chk("rst_b_valid", bus.axi_b_valid, 0);
    chk("rst_w_ready", bus.axi_w_ready, 0);
    chk("rst_sram_en", bus.sram_en, 0);
    chk("rst_sram_wen", bus.sram_wen, 0);
    chk("rst_r_data", bus.axi_r_data, 0);
    chk("rst_r_id", bus.axi_r_id, 0);
    chk("rst_b_id", bus.axi_b_id, 0);
    chk("rst_ar_ready_idle", bus.axi_ar_ready, 1);
    chk("rst_aw_ready_idle", bus.axi_aw_ready, 1);
    @(posedge clock); #1;

    // single-beat read latency
    ready_mode = 2;
    send_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'b01);
    @(negedge clock);
    chk("t1_sram_en_T1", bus.sram_en, 1);
    chk("t1_sram_addr_T1", bus.sram_addr, 4);
    @(negedge clock);
    chk("t1_r_valid_T2", bus.axi_r_valid, 0);
    @(negedge clock);
    chk("t1_r_valid_T3", bus.axi_r_valid, 1);
    chk("t1_r_data", bus.axi_r_data, 32'hDEADBEEF);
    chk("t1_r_last", bus.axi_r_last, 1);
    chk("t1_r_id", bus.axi_r_id, 3);
    chk("t1_r_resp", bus.axi_r_resp, 0);
    wait_done();

    // INCR write burst of 1..4
    do_write(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 1'b1, -1, -1);
    chk("t2_mem40", mem[16'h40], 1);
    chk("t2_mem41", mem[16'h41], 2);
    chk("t2_mem42", mem[16'h42], 3);
    chk("t2_mem43", mem[16'h43], 4);
    chk("t2_b_id", last_bid, 5);
    chk("t2_b_resp", last_bresp, 0);

    // WRAP read from 0x0C
    ready_mode = 0;
    sram_log.delete(); last_bits = 0;
    do_read(4'd1, 32'h0C, 8'd3, 3'd2, 2'b10);
    chk("t3_nacc", sram_log.size(), 4);
    if (sram_log.size() == 4) begin
      chk("t3_addr0", sram_log[0], 3);
      chk("t3_addr1", sram_log[1], 0);
      chk("t3_addr2", sram_log[2], 1);
      chk("t3_addr3", sram_log[3], 2);
    end
    chk("t3_last_pattern", last_bits[3:0], 4'b0001);

    // R stall: data/last held, no SRAM traffic
    ready_mode = 1;
    send_ar(4'd2, 32'h40, 8'd1, 3'd2, 2'b01);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.axi_r_valid && n < 50);
    if (!bus.axi_r_valid) timeout_fail("t4_r_valid");
    repeat (5) begin
      @(negedge clock);
      chk("t4_stall_valid", bus.axi_r_valid, 1);
      if (r_q.size() != 0) chk("t4_stall_data", bus.axi_r_data, r_q[0].data);
      chk("t4_stall_last", bus.axi_r_last, 0);
      chk("t4_stall_en", bus.sram_en, 0);
    end
    ready_mode = 2;
    wait_done();

    // simultaneous AR/AW: read first, then strb-3 write with early w_last
    @(posedge clock); #1;
    bus.axi_ar_id = 4'd7; bus.axi_ar_addr = 32'h20; bus.axi_ar_len = 8'd1;
    bus.axi_ar_size = 3'd2; bus.axi_ar_burst = 2'b01; bus.axi_ar_valid = 1'b1;
    bus.axi_aw_id = 4'd9; bus.axi_aw_addr = 32'h200; bus.axi_aw_len = 8'd1;
    bus.axi_aw_size = 3'd2; bus.axi_aw_burst = 2'b01; bus.axi_aw_valid = 1'b1;
    @(negedge clock);
    chk("t5_ar_ready", bus.axi_ar_ready, 1);
    chk("t5_aw_ready", bus.axi_aw_ready, 0);
    @(posedge clock); #1;
    bus.axi_ar_valid = 1'b0;
    push_read_model(4'd7, 32'h20, 8'd1, 3'd2, 2'b01);
    leak = 0; n = 0;
    do begin
      @(negedge clock); n++;
      if (bus.axi_aw_ready) leak = 1;
    end while (!(bus.axi_r_valid && bus.axi_r_ready && bus.axi_r_last) && n < 100);
    chk("t5_aw_blocked", leak, 0);
    wen_log.delete();
    do_write(4'd9, 32'h200, 8'd1, 3'd2, 2'b01, 4'h3, 1'b1, 0, -1);
    chk("t5_nwen", wen_log.size(), 2);
    if (wen_log.size() == 2) begin
      chk("t5_wen0", wen_log[0], 4'h3);
      chk("t5_wen1", wen_log[1], 4'h3);
    end
    chk("t5_bresp", last_bresp, 2'b10);
    chk("t5_bid", last_bid, 9);

    // reset during beat 2 of a 4-beat write
    do_write(4'd4, 32'h300, 8'd3, 3'd2, 2'b01, 4'hF, 1'b1, -1, 2);
    @(negedge clock);
    chk("t6_w_ready", bus.axi_w_ready, 0);
    chk("t6_b_valid", bus.axi_b_valid, 0);
    chk("t6_sram_en", bus.sram_en, 0);
    chk("t6_ar_ready", bus.axi_ar_ready, 1);
    repeat (4) begin
      @(negedge clock);
      chk("t6_quiet_en", bus.sram_en, 0);
    end
    chk("t6_memC0", mem[16'hC0], 1);
    chk("t6_memC1", mem[16'hC1], 2);
    chk("t6_memC2", mem[16'hC2], ref_mem[16'hC2]);
    @(posedge clock); #1;

    // randomized bursts against the model
    ready_mode = 0;
    for (int t = 0; t < 80; t++) begin
      rid    = 4'($urandom);
      rburst = 2'($urandom_range(0, 3));
      rsize  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (rburst == 2'b10) rlen = (8'd1 << $urandom_range(1, 4)) - 8'd1;
      else                 rlen = 8'($urandom_range(0, 17));
      raddr = 32'($urandom_range(0, 32'hFFF));
      if ($urandom_range(0, 3) == 0) raddr = raddr | 32'hA5A40000;
      if ($urandom_range(0, 1) == 1) begin
        do_read(rid, raddr, rlen, rsize, rburst);
      end else begin
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rlen))) : -1;
        do_write(rid, raddr, rlen, rsize, rburst, 4'h0, 1'b0, n, -1);
      end
    end
    wait_done();
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
